// File: rtl/mips32_mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mips32_mc_ctrl_if
// Brief    : Control-to-datapath bundle for the MIPS32 multi-cycle controller.
// Revision : 1.0
// ============================================================================
interface mips32_mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             zero;
    logic             memReady;
    logic             pcWrite;
    logic             pcWriteCond;
    logic             iorD;
    logic             memRead;
    logic             memWrite;
    logic             irWrite;
    logic             memToReg;
    logic             regDst;
    logic             regWrite;
    logic             aluSrcA;
    logic [1:0]       aluSrcB;
    logic [1:0]       aluOp;
    logic [1:0]       pcSource;
    logic             illegalOp;
    logic             instrDone;
    logic [3:0]       state;
    logic [CNT_W-1:0] instrCount;

    modport master (
        input  opcode, zero, memReady,
        output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
               pcSource, illegalOp, instrDone, state, instrCount
    );

    modport slave (
        output opcode, zero, memReady,
        input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
               pcSource, illegalOp, instrDone, state, instrCount
    );
endinterface
`default_nettype wire

// File: rtl/mips32_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips32_mc_ctrl
// Brief    : Multi-cycle MIPS32 control FSM with memory stall and retire count.
// Revision : 1.0
// ============================================================================
module mips32_mc_ctrl #(
    parameter int CNT_W  = 32,
    parameter bit EXC_EN = 1'b1
) (
    input wire logic         clk,
    input wire logic         rst,
    mips32_mc_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_EXC    = 4'd12
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             w_legal;
    logic             w_done;
    logic             w_unused_zero;

    // The branch decision is made in the datapath (pcWriteCond AND zero).
    assign w_unused_zero = bus.zero;

    always_comb begin
        w_legal = 1'b0;
        case (bus.opcode)
            c_OP_RTYPE, c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_J, c_OP_ADDI: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_count <= '0;
        end else begin
            if (w_done) begin
                r_count <= r_count + 1'b1;
            end
            case (r_state)
                S_FETCH:  if (bus.memReady) r_state <= S_DECODE;
                S_DECODE: begin
                    case (bus.opcode)
                        c_OP_RTYPE:      r_state <= S_EXEC;
                        c_OP_LW, c_OP_SW: r_state <= S_MEMADR;
                        c_OP_BEQ:        r_state <= S_BRANCH;
                        c_OP_J:          r_state <= S_JUMP;
                        c_OP_ADDI:       r_state <= S_ADDIEX;
                        default:         r_state <= EXC_EN ? S_EXC : S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= (bus.opcode == c_OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (bus.memReady) r_state <= S_MEMWB;
                S_MEMWR:  if (bus.memReady) r_state <= S_FETCH;
                S_EXEC:   r_state <= S_RWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Retirement: final state of each instruction, or an illegal opcode
    // silently dropped in DECODE when exceptions are disabled.
    always_comb begin
        w_done = 1'b0;
        if (!rst) begin
            case (r_state)
                S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB, S_EXC: w_done = 1'b1;
                S_MEMWR:  w_done = bus.memReady;
                S_DECODE: w_done = !EXC_EN && !w_legal;
                default:  w_done = 1'b0;
            endcase
        end
    end

    always_comb begin
        bus.pcWrite     = 1'b0;
        bus.pcWriteCond = 1'b0;
        bus.iorD        = 1'b0;
        bus.memRead     = 1'b0;
        bus.memWrite    = 1'b0;
        bus.irWrite     = 1'b0;
        bus.memToReg    = 1'b0;
        bus.regDst      = 1'b0;
        bus.regWrite    = 1'b0;
        bus.aluSrcA     = 1'b0;
        bus.aluSrcB     = 2'b00;
        bus.aluOp       = 2'b00;
        bus.pcSource    = 2'b00;
        bus.illegalOp   = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    bus.memRead = 1'b1;
                    bus.aluSrcB = 2'b01;
                    bus.irWrite = bus.memReady;
                    bus.pcWrite = bus.memReady;
                end
                S_DECODE: bus.aluSrcB = 2'b11;
                S_MEMADR, S_ADDIEX: begin
                    bus.aluSrcA = 1'b1;
                    bus.aluSrcB = 2'b10;
                end
                S_MEMRD: begin
                    bus.iorD    = 1'b1;
                    bus.memRead = 1'b1;
                end
                S_MEMWB: begin
                    bus.memToReg = 1'b1;
                    bus.regWrite = 1'b1;
                end
                S_MEMWR: begin
                    bus.iorD     = 1'b1;
                    bus.memWrite = 1'b1;
                end
                S_EXEC: begin
                    bus.aluSrcA = 1'b1;
                    bus.aluOp   = 2'b10;
                end
                S_RWB: begin
                    bus.regDst   = 1'b1;
                    bus.regWrite = 1'b1;
                end
                S_BRANCH: begin
                    bus.aluSrcA     = 1'b1;
                    bus.aluOp       = 2'b01;
                    bus.pcWriteCond = 1'b1;
                    bus.pcSource    = 2'b01;
                end
                S_JUMP: begin
                    bus.pcWrite  = 1'b1;
                    bus.pcSource = 2'b10;
                end
                S_ADDIWB: bus.regWrite = 1'b1;
                S_EXC: begin
                    bus.pcWrite   = 1'b1;
                    bus.pcSource  = 2'b11;
                    bus.illegalOp = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.instrDone  = w_done;
    assign bus.state      = r_state;
    assign bus.instrCount = r_count;
endmodule
`default_nettype wire

// File: tb/tb_mips32_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips32_mc_ctrl
// Brief    : Directed bench for mips32_mc_ctrl (EXC_EN=1/CNT_W=32 and EXC_EN=0/CNT_W=2).
// Revision : 1.0
// ============================================================================
module tb_mips32_mc_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       memReady = 1'b0;
    int         checks = 0;
    int         errors = 0;

    mips32_mc_ctrl_if #(.CNT_W(32)) ifa ();
    mips32_mc_ctrl_if #(.CNT_W(2))  ifb ();

    assign ifa.opcode = opcode;
    assign ifa.zero = 1'b0;
    assign ifa.memReady = memReady;
    assign ifb.opcode = opcode;
    assign ifb.zero = 1'b1;
    assign ifb.memReady = memReady;

    mips32_mc_ctrl #(.CNT_W(32), .EXC_EN(1'b1)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
    mips32_mc_ctrl #(.CNT_W(2),  .EXC_EN(1'b0)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

    always #5 clk = ~clk;

    wire [17:0] w_act_a = {ifa.pcWrite, ifa.pcWriteCond, ifa.iorD, ifa.memRead, ifa.memWrite,
                           ifa.irWrite, ifa.memToReg, ifa.regDst, ifa.regWrite, ifa.aluSrcA,
                           ifa.aluSrcB, ifa.aluOp, ifa.pcSource, ifa.illegalOp, ifa.instrDone};
    wire [17:0] w_act_b = {ifb.pcWrite, ifb.pcWriteCond, ifb.iorD, ifb.memRead, ifb.memWrite,
                           ifb.irWrite, ifb.memToReg, ifb.regDst, ifb.regWrite, ifb.aluSrcA,
                           ifb.aluSrcB, ifb.aluOp, ifb.pcSource, ifb.illegalOp, ifb.instrDone};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each instruction is a list of state visits; memory-facing visits
    // linger while memReady is low, and the last visit retires the instruction.
    logic [3:0]  m_steps [2][8];
    int          m_len [2];
    int          m_pos [2];
    logic [31:0] m_cnt [2];

    function automatic bit waits(input logic [3:0] c);
        return (c == 4'd0) || (c == 4'd3) || (c == 4'd5);
    endfunction

    task automatic build(input int d, input logic [5:0] op);
        logic [3:0] s [5];
        int n;
        for (int i = 0; i < 5; i++) s[i] = 4'd0;
        s[1] = 4'd1;
        n = 2;
        case (op)
            6'h00: begin s[2] = 4'd6;  s[3] = 4'd7;  n = 4; end
            6'h23: begin s[2] = 4'd2;  s[3] = 4'd3;  s[4] = 4'd4; n = 5; end
            6'h2B: begin s[2] = 4'd2;  s[3] = 4'd5;  n = 4; end
            6'h04: begin s[2] = 4'd8;  n = 3; end
            6'h02: begin s[2] = 4'd9;  n = 3; end
            6'h08: begin s[2] = 4'd10; s[3] = 4'd11; n = 4; end
            default: if (d == 0) begin s[2] = 4'd12; n = 3; end
        endcase
        for (int i = 0; i < n; i++) m_steps[d][i] = s[i];
        m_len[d] = n;
    endtask

    function automatic logic [17:0] exp_out(input logic [3:0] c, input logic rdy, input bit last);
        logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, ill, done;
        logic [1:0] sb, op, ps;
        {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
        sb = 2'd0; op = 2'd0; ps = 2'd0;
        case (c)
            4'd0:  begin mr = 1'b1; sb = 2'd1; irw = rdy; pw = rdy; end
            4'd1:  sb = 2'd3;
            4'd2:  begin sa = 1'b1; sb = 2'd2; end
            4'd3:  begin iord = 1'b1; mr = 1'b1; end
            4'd4:  begin m2r = 1'b1; rw = 1'b1; end
            4'd5:  begin iord = 1'b1; mw = 1'b1; end
            4'd6:  begin sa = 1'b1; op = 2'd2; end
            4'd7:  begin rd = 1'b1; rw = 1'b1; end
            4'd8:  begin sa = 1'b1; op = 2'd1; pwc = 1'b1; ps = 2'd1; end
            4'd9:  begin pw = 1'b1; ps = 2'd2; end
            4'd10: begin sa = 1'b1; sb = 2'd2; end
            4'd11: rw = 1'b1;
            4'd12: begin pw = 1'b1; ps = 2'd3; ill = 1'b1; end
            default: ;
        endcase
        done = last && (!waits(c) || rdy);
        return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, ill, done};
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_len[d] = 1; m_pos[d] = 0; m_cnt[d] = 0;
            for (int i = 0; i < 8; i++) m_steps[d][i] = 4'd0;
        end
    end

    always @(negedge clk) begin
        logic [17:0] act, exp;
        logic [3:0]  code, st;
        logic [31:0] cnt, ecnt;
        for (int d = 0; d < 2; d++) begin
            act  = (d == 0) ? w_act_a : w_act_b;
            st   = (d == 0) ? ifa.state : ifb.state;
            cnt  = (d == 0) ? ifa.instrCount : {30'd0, ifb.instrCount};
            code = 4'd0;
            exp  = '0;
            if (!rst) begin
                if (m_pos[d] == 0) build(d, opcode);
                code = m_steps[d][m_pos[d]];
                exp  = exp_out(code, memReady, m_pos[d] == m_len[d] - 1);
            end
            chk(d == 0 ? "ctrl_a" : "ctrl_b", {14'd0, act}, {14'd0, exp});
            if (!rst) begin
                ecnt = (d == 0) ? m_cnt[0] : (m_cnt[1] & 32'd3);
                chk(d == 0 ? "state_a" : "state_b", {28'd0, st}, {28'd0, code});
                chk(d == 0 ? "count_a" : "count_b", cnt, ecnt);
            end
            if (rst) begin
                m_pos[d] = 0;
                m_cnt[d] = 0;
            end else begin
                if (exp[0]) m_cnt[d] = m_cnt[d] + 1;
                if (!(waits(code) && !memReady)) begin
                    m_pos[d] = m_pos[d] + 1;
                    if (m_pos[d] >= m_len[d]) m_pos[d] = 0;
                end
            end
        end
    end

    task automatic cyc(input logic rdy);
        memReady = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [5:0] op);
        rst = 1'b1;
        opcode = op;
        cyc(1'b0);
        cyc(1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // R-type: FETCH, DECODE, EXEC, RWB
        do_reset(6'h00);
        repeat (3) cyc(1'b1);
        chk("rtype_rwb_regwrite", {30'd0, ifa.regWrite, ifa.regDst}, 32'd3);
        cyc(1'b1);
        chk("rtype_count", ifa.instrCount, 32'd1);
        chk("rtype_state", {28'd0, ifa.state}, 32'd0);

        // lw with two stall cycles in FETCH and in MEMRD: 9 cycles
        do_reset(6'h23);
        cyc(1'b0); cyc(1'b0); cyc(1'b1);
        cyc(1'b1); cyc(1'b1);
        cyc(1'b0); cyc(1'b0);
        chk("lw_memrd_iord", {30'd0, ifa.iorD, ifa.memRead}, 32'd3);
        cyc(1'b1);
        chk("lw_memwb", {30'd0, ifa.memToReg, ifa.regWrite}, 32'd3);
        cyc(1'b1);
        chk("lw_count", ifa.instrCount, 32'd1);
        chk("lw_state", {28'd0, ifa.state}, 32'd0);

        // sw: FETCH, DECODE, MEMADR, MEMWR
        do_reset(6'h2B);
        repeat (3) cyc(1'b1);
        chk("sw_memwrite", {29'd0, ifa.memWrite, ifa.iorD, ifa.memRead}, 32'd6);
        cyc(1'b1);
        chk("sw_count", ifa.instrCount, 32'd1);

        // beq then j
        do_reset(6'h04);
        repeat (2) cyc(1'b1);
        chk("beq_ctrl", {27'd0, ifa.pcWriteCond, ifa.pcSource, ifa.aluOp}, 32'b1_01_01);
        cyc(1'b1);
        opcode = 6'h02;
        repeat (2) cyc(1'b1);
        chk("j_ctrl", {29'd0, ifa.pcWrite, ifa.pcSource}, 32'b1_10);
        cyc(1'b1);
        chk("beq_j_count", ifa.instrCount, 32'd2);

        // illegal opcode: exception on A, silent retire on B
        do_reset(6'h3F);
        repeat (2) cyc(1'b1);
        chk("exc_state_a", {28'd0, ifa.state}, 32'd12);
        chk("exc_ill_a", {29'd0, ifa.illegalOp, ifa.pcSource}, 32'b1_11);
        chk("nop_state_b", {28'd0, ifb.state}, 32'd0);
        chk("nop_ill_b", {31'd0, ifb.illegalOp}, 32'd0);
        cyc(1'b1);
        chk("exc_count_a", ifa.instrCount, 32'd1);

        // reset during a MEMRD stall
        do_reset(6'h23);
        repeat (3) cyc(1'b1);
        cyc(1'b0); cyc(1'b0);
        chk("stall_state", {28'd0, ifa.state}, 32'd3);
        rst = 1'b1;
        #1;
        chk("rst_outputs_zero", {14'd0, w_act_a}, 32'd0);
        cyc(1'b0);
        chk("rst_state", {28'd0, ifa.state}, 32'd0);
        chk("rst_count", ifa.instrCount, 32'd0);
        rst = 1'b0;

        // five jumps: B's 2-bit counter wraps to 1
        do_reset(6'h02);
        repeat (15) cyc(1'b1);
        chk("wrap_count_a", ifa.instrCount, 32'd5);
        chk("wrap_count_b", {30'd0, ifb.instrCount}, 32'd1);

        cyc(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
